ssd_readback: RTL and testbench

- Receive-side counterpart of the seven-segment hex drive path.
- Samples the multiplexed, active-low anode and segment lines driving the board display and recovers the hex digit and dot shown on each position.
- Used by the Pong score path for self-check and readback, and by the bench as an on-chip scoreboard tap.
- Classifies each stable segment pattern as valid hex, blank or illegal.

---
 rtl/ssd_pkg.sv | 17 +
 rtl/ssd_seg_decode.sv | 24 ++
 rtl/ssd_readback.sv | 163 ++++++++++++++++
 tb/tb_ssd_readback.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment readback path: segment code table,
// blank pattern, digit width and the capture FSM state encoding.
package ssd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low a..g patterns, indexed by the nibble they display.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational seven-segment pattern decoder: maps active-low a..g to a hex
// nibble, flags table hits and the all-dark blank pattern.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0]         seg,
  output logic [DIGIT_W-1:0] nibble,
  output logic               hit,
  output logic               blank
);

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg == SEG_CODES[k]) begin
        nibble = DIGIT_W'(k);
        hit    = 1'b1;
      end
    end
    blank = (seg == SEG_BLANK);
  end

endmodule

// File: rtl/ssd_readback.sv
// Recovers per-position hex digits and dots from a multiplexed active-low
// seven-segment drive. Optional input synchronizer: SSD_READBACK_SYNC_EN.
module ssd_readback
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS-1:0]         an,
  input  logic [7:0]                    seg,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]         dots,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic                          frame_done,
  output logic                          code_err
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  // Capture fires on the edge that would move the counter to CNT_MAX, so the
  // decoded value is visible exactly STABLE_CYCLES cycles after it appears.
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

  logic [SW-1:0] in_w;

`ifdef SSD_READBACK_SYNC_EN
  logic [SW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {an, seg};
      sync2_q <= sync1_q;
    end
  end

  assign in_w = sync2_q;
`else
  assign in_w = {an, seg};
`endif

  logic [NUM_DIGITS-1:0] an_w, an_inv;
  logic [7:0]            seg_w;
  assign an_w   = in_w[SW-1:8];
  assign seg_w  = in_w[7:0];
  assign an_inv = ~an_w;

  logic [DIGIT_W-1:0] dec_nib;
  logic               dec_hit, dec_blank;

  ssd_seg_decode u_dec (
    .seg    (seg_w[6:0]),
    .nibble (dec_nib),
    .hit    (dec_hit),
    .blank  (dec_blank)
  );

  logic [SW-1:0]                       smp_q, smp_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  state_e                              state_q, state_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits_q, digits_d;
  logic [NUM_DIGITS-1:0]               dots_q, dots_d;
  logic [NUM_DIGITS-1:0]               valid_q, valid_d;
  logic [NUM_DIGITS-1:0]               seen_q, seen_d;
  logic                                frame_done_q, frame_done_d;
  logic                                code_err_q, code_err_d;

  logic changed, an_dark, multi_low, capture;
  assign changed   = (in_w != smp_q);
  assign an_dark   = &an_w;
  assign multi_low = |(an_inv & (an_inv - NUM_DIGITS'(1)));

  always_comb begin
    smp_d   = in_w;
    cnt_d   = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:   if (!an_dark) state_d = SETTLE;
      SETTLE: begin
        if (changed) state_d = an_dark ? IDLE : SETTLE;
        else if (cnt_q == CNT_CAP) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD:   if (changed) state_d = an_dark ? IDLE : SETTLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    digits_d     = digits_q;
    dots_d       = dots_q;
    valid_d      = valid_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    code_err_d   = 1'b0;
    if (capture) begin
      if (multi_low) begin
        code_err_d = 1'b1;
      end else begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (an_inv[k]) begin
            seen_d[k] = 1'b1;
            if (dec_blank) begin
              valid_d[k] = 1'b0;
              dots_d[k]  = ~seg_w[7];
            end else if (dec_hit) begin
              digits_d[k] = dec_nib;
              dots_d[k]   = ~seg_w[7];
              valid_d[k]  = 1'b1;
            end else begin
              valid_d[k] = 1'b0;
              code_err_d = 1'b1;
            end
          end
        end
        // Frame completes even on an illegal capture; mask restarts at once.
        if (&seen_d) begin
          frame_done_d = 1'b1;
          seen_d       = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q        <= '1;
      cnt_q        <= '0;
      state_q      <= IDLE;
      digits_q     <= '0;
      dots_q       <= '0;
      valid_q      <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      smp_q        <= smp_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      digits_q     <= digits_d;
      dots_q       <= dots_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      code_err_q   <= code_err_d;
    end
  end

  assign digits      = digits_q;
  assign dots        = dots_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign code_err    = code_err_q;

endmodule

// File: tb/tb_ssd_readback.sv
// Directed bench for ssd_readback (4 digits, 16-cycle settle) with
// hand-computed expectations checked by immediate assertions.
module tb_ssd_readback;

`ifdef SSD_READBACK_SYNC_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = 4'hF;
  logic [7:0]  seg = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dots, digit_valid;
  logic        frame_done, code_err;

  int n_chk  = 0;
  int n_fail = 0;

  ssd_readback #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .dots        (dots),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .code_err    (code_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold one pattern for 20 cycles and check the pulses around its capture.
  task automatic run_digit(input string tag, input logic [3:0] a, input logic [7:0] s,
                           input logic fd, input logic ce);
    an  = a;
    seg = s;
    step(LAT - 1);
    chk({tag, "_pre_fd"}, frame_done, 1'b0);
    chk({tag, "_pre_ce"}, code_err, 1'b0);
    step(1);
    chk({tag, "_fd"}, frame_done, fd);
    chk({tag, "_ce"}, code_err, ce);
    step(1);
    chk({tag, "_post_fd"}, frame_done, 1'b0);
    chk({tag, "_post_ce"}, code_err, 1'b0);
    step(20 - LAT - 1);
  endtask

  initial begin
    step(3);
    chk("rst_digits", digits, 16'h0000);
    chk("rst_dots", dots, 4'h0);
    chk("rst_valid", digit_valid, 4'h0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_ce", code_err, 1'b0);
    rst = 1'b0;
    step(2);
    chk("idle_valid", digit_valid, 4'h0);

    // digit 3 on position 0, dot dark
    an = 4'hE; seg = 8'hB0;
    step(LAT - 1);
    chk("s1_early_valid", digit_valid, 4'h0);
    step(1);
    chk("s1_digits", digits, 16'h0003);
    chk("s1_valid", digit_valid, 4'h1);
    chk("s1_dots", dots, 4'h0);
    chk("s1_ce", code_err, 1'b0);
    step(20 - LAT);
    chk("s1_hold_valid", digit_valid, 4'h1);

    // toggle mid-settle restarts the count
    an = 4'hD; seg = 8'h92;
    step(8);
    seg = 8'h12;
    step(LAT - 1);
    chk("s2_early_valid", digit_valid, 4'h1);
    step(1);
    chk("s2_digits", digits, 16'h0053);
    chk("s2_dots", dots, 4'h2);
    chk("s2_valid", digit_valid, 4'h3);
    step(4);

    // scan with a blank on position 2
    run_digit("s3p0", 4'hE, 8'hF9, 1'b0, 1'b0);
    run_digit("s3p1", 4'hD, 8'hA4, 1'b0, 1'b0);
    run_digit("s3p2", 4'hB, 8'h7F, 1'b0, 1'b0);
    run_digit("s3p3", 4'h7, 8'h8E, 1'b1, 1'b0);
    chk("s3_digits", digits, 16'hF021);
    chk("s3_valid", digit_valid, 4'hB);
    chk("s3_dots", dots, 4'h4);

    // two anodes low
    run_digit("s4", 4'hC, 8'h40, 1'b0, 1'b1);
    chk("s4_digits", digits, 16'hF021);
    chk("s4_valid", digit_valid, 4'hB);
    chk("s4_dots", dots, 4'h4);

    // illegal pattern on position 3
    run_digit("s5", 4'h7, 8'h7E, 1'b0, 1'b1);
    chk("s5_valid", digit_valid, 4'h3);
    chk("s5_digits", digits, 16'hF021);
    chk("s5_dots", dots, 4'h4);

    // position 3 already seen: frame completes after position 2
    run_digit("s6p0", 4'hE, 8'hC0, 1'b0, 1'b0);
    run_digit("s6p1", 4'hD, 8'hA1, 1'b0, 1'b0);
    run_digit("s6p2", 4'hB, 8'h06, 1'b1, 1'b0);
    chk("s6_digits", digits, 16'hFED0);
    chk("s6_valid", digit_valid, 4'h7);
    chk("s6_dots", dots, 4'h4);

    // illegal capture completing the frame
    run_digit("s7p0", 4'hE, 8'hF9, 1'b0, 1'b0);
    run_digit("s7p1", 4'hD, 8'hF9, 1'b0, 1'b0);
    run_digit("s7p2", 4'hB, 8'hF9, 1'b0, 1'b0);
    run_digit("s7p3", 4'h7, 8'hFE, 1'b1, 1'b1);
    chk("s7_digits", digits, 16'hF111);
    chk("s7_valid", digit_valid, 4'h7);
    chk("s7_dots", dots, 4'h0);

    // reset mid-settle
    an = 4'hE; seg = 8'hC0;
    step(10);
    rst = 1'b1;
    step(1);
    chk("s8_rst_digits", digits, 16'h0000);
    chk("s8_rst_valid", digit_valid, 4'h0);
    chk("s8_rst_dots", dots, 4'h0);
    chk("s8_rst_fd", frame_done, 1'b0);
    chk("s8_rst_ce", code_err, 1'b0);
    rst = 1'b0;
    step(LAT - 1);
    chk("s8_early_valid", digit_valid, 4'h0);
    step(1);
    chk("s8_valid", digit_valid, 4'h1);
    chk("s8_digits", digits, 16'h0000);
    chk("s8_ce", code_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
